// File: rtl/encoder_4to2_reg_if.sv
// Handshake bundle for the registered priority encoder.
// The master side offers one-hot words and consumes results; the slave side
// is the encoder itself.
interface encoder_4to2_reg_if #(
    parameter int WIDTH = 4,
    parameter int OUT_W = 2,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] y;
    logic             zero;
    logic             multi;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid,
        output d,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y,
        input  zero,
        input  multi,
        input  err_cnt
    );

    modport slave (
        input  in_valid,
        input  d,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y,
        output zero,
        output multi,
        output err_cnt
    );
endinterface

// File: rtl/encoder_4to2_reg.sv
// Registered priority encoder with a one-entry output buffer.
// Accepts a one-hot word on a valid/ready handshake and returns the index of
// the highest set bit one clock later, together with zero / not-one-hot flags.
// Malformed words (zero or multiple bits set) are tallied in a saturating
// counter that is independent of the output side.
module encoder_4to2_reg #(
    parameter int WIDTH = 4,
    parameter int OUT_W = 2,   // must equal log2(WIDTH)
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    encoder_4to2_reg_if.slave bus
);

    // The buffer state is the only thing that decides whether a result is held,
    // so out_valid is simply "state is FULL".
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q,   state_d;
    logic [OUT_W-1:0] y_q,       y_d;
    logic             zero_q,    zero_d;
    logic             multi_q,   multi_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             in_ready;
    logic             accept;
    logic [OUT_W-1:0] y_enc;
    logic             zero_enc;
    logic             multi_enc;
    logic             seen;

    // Priority encode d from the MSB down; any 1 below an already-seen 1 marks
    // the word as not one-hot.
    always_comb begin
        y_enc     = '0;
        multi_enc = 1'b0;
        seen      = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bus.d[i]) begin
                if (seen) begin
                    multi_enc = 1'b1;
                end else begin
                    y_enc = OUT_W'(i);
                end
                seen = 1'b1;
            end
        end
        zero_enc = ~seen;
    end

    // Handshake: a slot is free when empty or when the held result leaves this
    // cycle, which lets back-to-back words stream without a bubble.
    always_comb begin
        in_ready = (state_q == EMPTY) | bus.out_ready;
        accept   = bus.in_valid & in_ready;
    end

    // Next-state and next-output computation for the buffer and the counter.
    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        zero_d    = zero_q;
        multi_d   = multi_q;
        err_cnt_d = err_cnt_q;
        if (accept) begin
            state_d = FULL;
            y_d     = y_enc;
            zero_d  = zero_enc;
            multi_d = multi_enc;
            if ((zero_enc | multi_enc) && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end else if (bus.out_ready) begin
            // Result consumed with nothing new behind it; the old payload is
            // left in place but no longer flagged valid.
            state_d = EMPTY;
        end
    end

    // State and registered outputs; reset drops any held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            y_q       <= '0;
            zero_q    <= 1'b0;
            multi_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            zero_q    <= zero_d;
            multi_q   <= multi_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == FULL);
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.multi     = multi_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_encoder_4to2_reg.sv
// Directed bench for encoder_4to2_reg: a default instance (CNT_W=8) and a
// narrow-counter instance (CNT_W=2) share the same stimulus so saturation
// can be observed alongside normal operation.
module tb_encoder_4to2_reg;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] d;
    logic       out_ready;

    int n_checks;
    int n_fail;

    encoder_4to2_reg_if #(.WIDTH(4), .OUT_W(2), .CNT_W(8)) bus8 ();
    encoder_4to2_reg_if #(.WIDTH(4), .OUT_W(2), .CNT_W(2)) bus2 ();

    assign bus8.in_valid  = in_valid;
    assign bus8.d         = d;
    assign bus8.out_ready = out_ready;
    assign bus2.in_valid  = in_valid;
    assign bus2.d         = d;
    assign bus2.out_ready = out_ready;

    encoder_4to2_reg #(.WIDTH(4), .OUT_W(2), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    encoder_4to2_reg #(.WIDTH(4), .OUT_W(2), .CNT_W(2)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [1:0] y;
        logic       zero;
        logic       multi;
        int         err8;
        int         err2;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_result(input string tag, input int yv, input int zv, input int mv);
        chk({tag, " out_valid"}, int'(bus8.out_valid), 1);
        chk({tag, " y"},         int'(bus8.y), yv);
        chk({tag, " zero"},      int'(bus8.zero), zv);
        chk({tag, " multi"},     int'(bus8.multi), mv);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{4'b0001, 2'd0, 1'b0, 1'b0, 0, 0};
        vecs[1] = '{4'b0010, 2'd1, 1'b0, 1'b0, 0, 0};
        vecs[2] = '{4'b0100, 2'd2, 1'b0, 1'b0, 0, 0};
        vecs[3] = '{4'b1000, 2'd3, 1'b0, 1'b0, 0, 0};
        vecs[4] = '{4'b0000, 2'd0, 1'b1, 1'b0, 1, 1};
        vecs[5] = '{4'b1010, 2'd3, 1'b0, 1'b1, 2, 2};
        vecs[6] = '{4'b1111, 2'd3, 1'b0, 1'b1, 3, 3};
        vecs[7] = '{4'b0110, 2'd2, 1'b0, 1'b1, 4, 3};
        vecs[8] = '{4'b0011, 2'd1, 1'b0, 1'b1, 5, 3};
        vecs[9] = '{4'b1001, 2'd3, 1'b0, 1'b1, 6, 3};

        // Scenario 1: reset held with a word offered.
        rst       = 1'b1;
        in_valid  = 1'b1;
        d         = 4'b1000;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("rst out_valid", int'(bus8.out_valid), 0);
            chk("rst y",         int'(bus8.y), 0);
            chk("rst err_cnt",   int'(bus8.err_cnt), 0);
            $display("reset cycle %0d: out_valid=%0b y=%0d err_cnt=%0d",
                     c, bus8.out_valid, bus8.y, bus8.err_cnt);
        end

        // Scenario 2: single transfer, then drain.
        @(negedge clk);
        rst = 1'b0; d = 4'b0100; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk_result("single", 2, 0, 0);
        $display("single d=0100 -> y=%0d zero=%0b multi=%0b", bus8.y, bus8.zero, bus8.multi);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain out_valid", int'(bus8.out_valid), 0);

        // Scenario 3: stall with a competing word offered.
        @(negedge clk);
        d = 4'b0010; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        chk_result("stall capture", 1, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            d = 4'b1000; in_valid = 1'b1; out_ready = 1'b0;
            #1;
            chk("stall in_ready", int'(bus8.in_ready), 0);
            @(posedge clk); #1;
            chk_result("stall hold", 1, 0, 0);
            $display("stall cycle %0d: in_ready=0 y=%0d", c, bus8.y);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("release in_ready", int'(bus8.in_ready), 1);
        @(posedge clk); #1;
        chk_result("release", 3, 0, 0);
        $display("release -> y=%0d", bus8.y);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("release drain", int'(bus8.out_valid), 0);

        // Scenarios 4/5: back-to-back table stream, including malformed words.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            d = vecs[i].d; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk("stream in_ready", int'(bus8.in_ready), 1);
            @(posedge clk); #1;
            chk_result("stream", int'(vecs[i].y), int'(vecs[i].zero), int'(vecs[i].multi));
            chk("stream err_cnt",    int'(bus8.err_cnt), vecs[i].err8);
            chk("stream err_cnt_w2", int'(bus2.err_cnt), vecs[i].err2);
            $display("vec %0d d=%b -> y=%0d zero=%0b multi=%0b err=%0d err_w2=%0d",
                     i, vecs[i].d, bus8.y, bus8.zero, bus8.multi, bus8.err_cnt, bus2.err_cnt);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream drain", int'(bus8.out_valid), 0);

        // Scenario 6: reset while FULL and stalled, then a fresh transfer.
        @(negedge clk);
        d = 4'b0001; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("pre-rst out_valid", int'(bus8.out_valid), 1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid rst out_valid", int'(bus8.out_valid), 0);
        chk("mid rst err_cnt",   int'(bus8.err_cnt), 0);
        chk("mid rst err_cnt_w2", int'(bus2.err_cnt), 0);
        chk("mid rst y",         int'(bus8.y), 0);
        $display("reset while full: out_valid=%0b err_cnt=%0d", bus8.out_valid, bus8.err_cnt);
        @(negedge clk);
        rst = 1'b0; d = 4'b0100; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk_result("post rst", 2, 0, 0);
        $display("post reset d=0100 -> y=%0d", bus8.y);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post rst drain", int'(bus8.out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
